// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
//   pll_seq_state_e : sequencer FSM states (3-bit encoding, unused codes are illegal)
//   LOST_CNT_W      : width of the saturating lock-loss event counter
//   lost_cnt_inc    : saturating increment for the lock-loss counter
package pll_seq_pkg;

  localparam int unsigned LOST_CNT_W = 8;

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } pll_seq_state_e;

  function automatic logic [LOST_CNT_W-1:0] lost_cnt_inc(input logic [LOST_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + LOST_CNT_W'(1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-stage 1-bit synchronizer with asynchronous active-low reset.
// All stages reset to 0, so the synchronized output reads "not asserted" out of reset.
//   clk_i  : destination clock
//   rst_ni : async active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output, STAGES cycles of latency
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout/retry, requires the
// lock to stay up for a qualification window, then releases the system reset. Runs on the PLL
// reference clock so it works before the PLL has locked.
//
// Ports:
//   refclk        in  reference clock
//   rst_n         in  async active-low reset
//   pll_locked    in  PLL lock flag, asynchronous to refclk
//   pll_rst       out PLL reset, active high
//   sys_rst_n     out system reset, active low, released only in run
//   sys_ready     out high only in run
//   fault         out sticky lock failure (always 0 unless PLLSEQ_FAULT_EN is defined)
//   lock_lost_cnt out run-state lock-loss events, saturating
//
// Build option: define PLLSEQ_FAULT_EN to add the retry counter and the sticky fault state.
// Without it, lock timeouts retry forever.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 1000000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RETRY_MAX          = 8,
  parameter int unsigned CNT_W              = 20
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  sys_ready,
  output logic                  fault,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

  // Parameter sanity checks at elaboration.
  if (SYNC_STAGES < 2) begin : gen_bad_sync_stages
    $error("SYNC_STAGES must be at least 2");
  end
  if (PLL_RST_CYCLES < 1) begin : gen_bad_rst_cycles
    $error("PLL_RST_CYCLES must be at least 1");
  end
  if (LOCK_TIMEOUT < 1) begin : gen_bad_timeout
    $error("LOCK_TIMEOUT must be at least 1");
  end
  if (LOCK_STABLE_CYCLES < 1) begin : gen_bad_stable
    $error("LOCK_STABLE_CYCLES must be at least 1");
  end
  if (RETRY_MAX < 1) begin : gen_bad_retry
    $error("RETRY_MAX must be at least 1");
  end

  // Terminal counts of the shared counter, one per timed state.
  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);

`ifdef PLLSEQ_FAULT_EN
  localparam int unsigned  RetryW    = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;
  localparam logic [RetryW-1:0] RetryLast = RetryW'(RETRY_MAX - 1);

  logic [RetryW-1:0] retry_q;
  logic [RetryW-1:0] retry_d;
`endif

  pll_seq_state_e         state_q;
  pll_seq_state_e         state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [LOST_CNT_W-1:0]  lost_q;
  logic [LOST_CNT_W-1:0]  lost_d;
  logic                   locked_s;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_locked_sync (
    .clk_i (refclk),
    .rst_ni(rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // Next-state logic. The counter free-runs in timed states and is cleared on every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    lost_d  = lost_q;
`ifdef PLLSEQ_FAULT_EN
    retry_d = retry_q;
`endif
    case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        // Lock seen in the same cycle as the timeout takes priority.
        if (locked_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d = '0;
`ifdef PLLSEQ_FAULT_EN
          if (retry_q == RetryLast) begin
            state_d = StFault;
          end else begin
            retry_d = retry_q + RetryW'(1);
            state_d = StPllRst;
          end
`else
          state_d = StPllRst;
`endif
        end
      end
      StStable: begin
        // Any drop of lock restarts qualification without counting as a retry.
        if (!locked_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
`ifdef PLLSEQ_FAULT_EN
          retry_d = '0;
`endif
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = StPllRst;
          lost_d  = lost_cnt_inc(lost_q);
        end
      end
`ifdef PLLSEQ_FAULT_EN
      StFault: begin
        // Sticky: only rst_n leaves this state.
        cnt_d = '0;
      end
`endif
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StPllRst;
      cnt_q   <= '0;
      lost_q  <= '0;
`ifdef PLLSEQ_FAULT_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
`ifdef PLLSEQ_FAULT_EN
      retry_q <= retry_d;
`endif
    end
  end

  // Moore output decode from the registered state; async reset reaches the outputs immediately.
  always_comb begin
    pll_rst   = 1'b0;
    sys_rst_n = 1'b0;
    sys_ready = 1'b0;
    fault     = 1'b0;
    case (state_q)
      StPllRst: pll_rst = 1'b1;
      StRun: begin
        sys_rst_n = 1'b1;
        sys_ready = 1'b1;
      end
`ifdef PLLSEQ_FAULT_EN
      StFault: fault = 1'b1;
`endif
      default: ;
    endcase
  end

  assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer. Stimulus pushes the expected output changes (cycle + value)
// into a queue; a monitor pops one entry each time the output vector changes and compares.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       sys_ready;
  logic       fault;
  logic [7:0] lock_lost_cnt;

  pll_reset_sequencer #(
    .SYNC_STAGES       (2),
    .PLL_RST_CYCLES    (4),
    .LOCK_TIMEOUT      (32),
    .LOCK_STABLE_CYCLES(8),
    .RETRY_MAX         (3),
    .CNT_W             (20)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .sys_ready    (sys_ready),
    .fault        (fault),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [11:0] vec;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] RstVec = 12'h800;

  logic [11:0] out_vec;
  logic [11:0] prev_vec = RstVec;
  assign out_vec = {pll_rst, sys_rst_n, sys_ready, fault, lock_lost_cnt};

  function automatic logic [11:0] mk(input logic pr, input logic sr, input logic rdy,
                                     input logic f, input logic [7:0] n);
    return {pr, sr, rdy, f, n};
  endfunction

  task automatic push(input int c, input logic [11:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cyc %0d)", name, got, req, cyc);
    end
  endtask

  // Monitor: every change of the output vector must match the next expected event.
  always @(negedge refclk) begin
    if (out_vec !== prev_vec) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %h@%0d required no change", out_vec, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.vec !== out_vec) begin
          errors++;
          $display("FAIL output_event: got %h@%0d required %h@%0d",
                   out_vec, cyc, mon_e.vec, mon_e.cyc);
        end
      end
      prev_vec = out_vec;
    end
  end

  // Drop lock from run, expect one reset pulse, relock and return to run with count n.
  task automatic lose_relock(input logic [7:0] n);
    int b;
    b = cyc;
    push(b + 3, mk(1'b1, 1'b0, 1'b0, 1'b0, n));
    push(b + 7, mk(1'b0, 1'b0, 1'b0, 1'b0, n));
    push(b + 21, mk(1'b0, 1'b1, 1'b1, 1'b0, n));
    pll_locked = 1'b0;
    tick(10);
    pll_locked = 1'b1;
    tick(20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int d;
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    #1 rst_n = 1'b0;
    tick(3);
    check("reset_state", out_vec, RstVec);

    // Clean bring-up: lock at cycle 10, run 11 cycles later.
    rst_n = 1'b1;
    b = cyc;
    push(b + 4, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    push(b + 21, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0));
    tick(10);
    pll_locked = 1'b1;
    tick(20);
    check("bringup_ready", {11'd0, sys_ready}, 12'd1);

    // Lock loss in run.
    lose_relock(8'd1);

    // Lock glitch during qualification: 5 high, 3 low, then high.
    b = cyc;
    push(b + 3, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd2));
    push(b + 7, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
    pll_locked = 1'b0;
    tick(10);
    d = cyc;
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    check("glitch_no_rst", {11'd0, pll_rst}, 12'd0);
    tick(3);
    pll_locked = 1'b1;
    push(d + 19, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd2));
    tick(20);

    // Async reset while qualifying lock.
    b = cyc;
    push(b + 3, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd3));
    push(b + 7, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd3));
    pll_locked = 1'b0;
    tick(10);
    pll_locked = 1'b1;
    tick(6);
    push(cyc, RstVec);
    #1 rst_n = 1'b0;
    pll_locked = 1'b0;
    #1 check("async_reset", out_vec, RstVec);
    tick(2);

    // No lock at all: 4-cycle pulses every 36 cycles, fault after the third timeout if enabled.
    rst_n = 1'b1;
    b = cyc;
    push(b + 4, 12'h000);
    push(b + 36, RstVec);
    push(b + 40, 12'h000);
    push(b + 72, RstVec);
    push(b + 76, 12'h000);
`ifdef PLLSEQ_FAULT_EN
    push(b + 108, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
`else
    push(b + 108, RstVec);
    push(b + 112, 12'h000);
    push(b + 144, RstVec);
    push(b + 148, 12'h000);
`endif
    tick(160);
`ifdef PLLSEQ_FAULT_EN
    check("fault_sticky", {11'd0, fault}, 12'd1);
`else
    check("fault_tied_low", {11'd0, fault}, 12'd0);
`endif
    push(cyc, RstVec);
    #1 rst_n = 1'b0;
    #1 check("reset_from_nolock", out_vec, RstVec);
    tick(2);

    // Bring up again, then 300 lock losses to saturate the counter.
    rst_n = 1'b1;
    b = cyc;
    push(b + 4, 12'h000);
    push(b + 21, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0));
    tick(10);
    pll_locked = 1'b1;
    tick(20);
    for (int i = 1; i <= 300; i++) begin
      lose_relock((i > 255) ? 8'd255 : 8'(i));
    end
    check("lost_saturated", {4'd0, lock_lost_cnt}, 12'd255);

    tick(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
